// File: rtl/uart_rx_cmd_decoder.sv
// Collects A, B, opcode bytes from the UART receiver, runs the ALU, hands the result to the TX.
// Optional parity-checked frames: define UART_RX_CMD_DECODER_PARITY_EN.
module uart_rx_cmd_decoder #(
    parameter int NB_DATA        = 8,
    parameter int NB_OPCODE      = 6,
    parameter int NB_TIMEOUT     = 20,
    parameter int TIMEOUT_CYCLES = 1000000,
`ifdef UART_RX_CMD_DECODER_PARITY_EN
    localparam int NB_RX = NB_DATA + 1
`else
    localparam int NB_RX = NB_DATA
`endif
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NB_RX-1:0]     i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_rx_frame_valid,
    input  logic [NB_DATA-1:0]   i_alu_result,
    input  logic                 i_tx_done,
    output logic [NB_DATA-1:0]   o_data_a,
    output logic [NB_DATA-1:0]   o_data_b,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_err_drop,
    output logic                 o_err_timeout
);

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_ALU,
        ST_TX_START,
        ST_TX_WAIT
    } state_t;

    localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_t                state, state_n;
    logic                  rx_done_d, tx_done_d;
    logic                  rx_stb, tx_done_stb, frame_ok;
    logic [NB_DATA-1:0]    field;
    logic [NB_TIMEOUT-1:0] cnt, cnt_n;
    logic [NB_DATA-1:0]    data_a_n, data_b_n, tx_data_n;
    logic [NB_OPCODE-1:0]  opcode_n;
    logic                  drop_n, timeout_n;

    assign rx_stb      = i_rx_done & ~rx_done_d;
    assign tx_done_stb = i_tx_done & ~tx_done_d;
    assign field       = i_rx_data[NB_RX-1 -: NB_DATA];

`ifdef UART_RX_CMD_DECODER_PARITY_EN
    // The parity bit itself was already judged by the receiver.
    assign frame_ok = i_rx_frame_valid | (i_rx_data[0] & 1'b0);
`else
    assign frame_ok = i_rx_frame_valid | 1'b1;
`endif

    assign o_tx_start = (state == ST_TX_START);
    assign o_busy     = (state == ST_ALU) || (state == ST_TX_START) ||
                        (state == ST_TX_WAIT);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= ST_WAIT_A;
            rx_done_d     <= 1'b0;
            tx_done_d     <= 1'b0;
            cnt           <= '0;
            o_data_a      <= '0;
            o_data_b      <= '0;
            o_opcode      <= '0;
            o_tx_data     <= '0;
            o_err_drop    <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            state         <= state_n;
            rx_done_d     <= i_rx_done;
            tx_done_d     <= i_tx_done;
            cnt           <= cnt_n;
            o_data_a      <= data_a_n;
            o_data_b      <= data_b_n;
            o_opcode      <= opcode_n;
            o_tx_data     <= tx_data_n;
            o_err_drop    <= drop_n;
            o_err_timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        data_a_n  = o_data_a;
        data_b_n  = o_data_b;
        opcode_n  = o_opcode;
        tx_data_n = o_tx_data;
        drop_n    = 1'b0;
        timeout_n = 1'b0;
        unique case (state)
            ST_WAIT_A: begin
                cnt_n = '0;
                if (rx_stb && frame_ok) begin
                    data_a_n = field;
                    state_n  = ST_WAIT_B;
                end else if (rx_stb) begin
                    drop_n = 1'b1;
                end
            end
            ST_WAIT_B, ST_WAIT_OP: begin
                // An arriving byte always beats a coincident timeout.
                if (rx_stb && frame_ok) begin
                    cnt_n = '0;
                    if (state == ST_WAIT_B) begin
                        data_b_n = field;
                        state_n  = ST_WAIT_OP;
                    end else begin
                        opcode_n = field[NB_OPCODE-1:0];
                        state_n  = ST_ALU;
                    end
                end else if (rx_stb) begin
                    drop_n = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                    state_n   = ST_WAIT_A;
                end else begin
                    cnt_n = cnt + NB_TIMEOUT'(1);
                end
            end
            ST_ALU: begin
                cnt_n     = '0;
                drop_n    = rx_stb;
                tx_data_n = i_alu_result;
                state_n   = ST_TX_START;
            end
            ST_TX_START: begin
                cnt_n   = '0;
                drop_n  = rx_stb;
                state_n = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                cnt_n  = '0;
                drop_n = rx_stb;
                if (tx_done_stb) state_n = ST_WAIT_A;
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_WAIT_A;
            end
        endcase
    end

endmodule

// File: doc/uart_rx_cmd_decoder.md
Name: uart_rx_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver. Consumes its received-byte strobe, data and frame-valid flag.
- Assembles a 3-byte command: operand A, then operand B, then opcode.
- Presents the operands and opcode to the combinational ALU, latches the ALU result and hands it to the UART transmitter with a start/done handshake.
- Also drops bytes that arrive while busy and aborts a command whose bytes stall too long.

Parameters:
- NB_DATA, 8, operand/result width; one UART byte.
- NB_OPCODE, 6, opcode width, taken from the LSBs of the third byte.
- NB_TIMEOUT, 20, inter-byte timeout counter width.
- TIMEOUT_CYCLES, 1000000, max i_clock cycles allowed between consecutive bytes of one command; must be < 2^NB_TIMEOUT.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_RX  received frame; NB_RX = NB_DATA, or NB_DATA+1 with the optional feature
- i_rx_done  in  1  receiver byte-ready level; may stay high for several clocks
- i_rx_frame_valid  in  1  receiver parity result
- i_alu_result  in  NB_DATA  combinational ALU output
- i_tx_done  in  1  transmitter finished level; may stay high for several clocks
- o_data_a  out  NB_DATA  operand A to ALU
- o_data_b  out  NB_DATA  operand B to ALU
- o_opcode  out  NB_OPCODE  opcode to ALU
- o_tx_data  out  NB_DATA  byte to transmit
- o_tx_start  out  1  one-cycle transmit request
- o_busy  out  1  high in ST_ALU, ST_TX_START and ST_TX_WAIT
- o_err_drop  out  1  one-cycle pulse: byte discarded
- o_err_timeout  out  1  one-cycle pulse: command aborted

Behaviour:
- Reset: all outputs 0, state ST_WAIT_A, edge registers 0, timeout counter 0.
- Byte strobe: rx_stb = i_rx_done & ~rx_done_d, where rx_done_d is a registered copy of i_rx_done. Exactly one strobe per byte regardless of level duration. i_rx_done high on the first cycle after reset counts as a strobe.
- tx_done edge: tx_done_stb = i_tx_done & ~tx_done_d, detected the same way.
- Data field: i_rx_data[NB_RX-1 -: NB_DATA]. The opcode is the low NB_OPCODE bits of that field.
- FSM:
  - ST_WAIT_A: on rx_stb, register o_data_a and go to ST_WAIT_B.
  - ST_WAIT_B: on rx_stb, register o_data_b and go to ST_WAIT_OP.
  - ST_WAIT_OP: on rx_stb, register o_opcode and go to ST_ALU.
  - ST_ALU: one cycle for the ALU to settle. Next edge: o_tx_data <= i_alu_result, go to ST_TX_START.
  - ST_TX_START: o_tx_start = 1 for exactly this cycle, then go to ST_TX_WAIT.
  - ST_TX_WAIT: on tx_done_stb, go to ST_WAIT_A.
- Latency: the opcode strobe edge leads to o_tx_start high 2 clocks later.
- o_data_a, o_data_b and o_opcode hold their values until overwritten by the next accepted byte.
- Busy drop: an rx_stb in ST_ALU, ST_TX_START or ST_TX_WAIT is discarded, o_err_drop pulses for 1 cycle, and the state is unchanged.
- Timeout:
  - Counter clears on every accepted byte and in ST_WAIT_A, and increments each clock in ST_WAIT_B and ST_WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_stb that cycle: go to ST_WAIT_A, o_err_timeout pulses, counter clears.
  - If rx_stb and the timeout coincide, the byte wins.
  - Partially received operands keep their values; they are not cleared.
- tx_done_stb outside ST_TX_WAIT is ignored.
- Reset mid-command or mid-transmit returns to the reset state immediately; no o_tx_start is issued.

Optional Feature:
- Macro UART_RX_CMD_DECODER_PARITY_EN.
- Defined:
  - NB_RX = NB_DATA+1; bit 0 is the received parity bit and is not used as data.
  - An rx_stb with i_rx_frame_valid=0 is discarded: o_err_drop pulses, state and timeout counter unchanged.
- Undefined:
  - NB_RX = NB_DATA.
  - i_rx_frame_valid is ignored; its port remains present.

Test Plan:
- Bytes 0x05, 0x03, 0x20 each with i_rx_done held 4 clocks, ALU returning 0x08 -> o_data_a=0x05, o_data_b=0x03, o_opcode=0x20. o_tx_data=0x08 with o_tx_start a single 1-cycle pulse 2 clocks after the third strobe. After an i_tx_done pulse, state returns to ST_WAIT_A.
- Byte 0x11 sent during ST_TX_WAIT -> o_err_drop pulses once. o_data_a, o_data_b and o_opcode unchanged. The next command is decoded normally.
- Bytes 0x0A, 0x0B, then no byte for TIMEOUT_CYCLES (test override 16) clocks -> o_err_timeout pulses once and state becomes ST_WAIT_A. Next bytes 0x01, 0x02, 0x20 form a fresh command with o_data_a=0x01.
- Third byte strobe on exactly the timeout cycle -> byte accepted, no o_err_timeout, o_tx_start follows.
- i_reset asserted in ST_TX_START and in ST_WAIT_OP -> next cycle all outputs 0, no o_tx_start. A subsequent full command works.
- With UART_RX_CMD_DECODER_PARITY_EN, second byte with i_rx_frame_valid=0 -> o_err_drop pulses, state stays ST_WAIT_B. A valid resend of 0x03 is accepted as operand B.
